// File: rtl/tx_link_pkg.sv
// rtl/tx_link_pkg.sv - K-code constants, scheduler states and symbol helper
package tx_link_pkg;

   localparam logic [7:0] K28_5 = 8'hBC;
   localparam logic [7:0] K27_7 = 8'hFB;
   localparam logic [7:0] K29_7 = 8'hFD;
   localparam logic [7:0] K23_7 = 8'hF7;
   localparam logic [7:0] K30_7 = 8'hFE;

   typedef enum logic [2:0] {DIS, ALIGN, IDLE, DATA, EOF, ABORT} state_t;

   typedef struct packed {
      logic       ena;
      logic       k;
      logic [7:0] din;
   } sym_t;

   function automatic sym_t ksym(input logic [7:0] code);
      return '{ena: 1'b1, k: 1'b1, din: code};
   endfunction

endpackage

// File: rtl/comma_interval_counter.sv
// rtl/comma_interval_counter.sv - saturating count of symbols since the last comma
module comma_interval_counter #(
   parameter int CNT_W          = 7,
   parameter int COMMA_INTERVAL = 64
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             clr,
   input  logic             inc,
   output logic [CNT_W-1:0] cnt,
   output logic             due
);

   localparam logic [CNT_W-1:0] LAST = CNT_W'(COMMA_INTERVAL - 1);

   always_ff @(posedge clk or negedge rst) begin
      if (!rst)
         cnt <= '0;
      else if (clr)
         cnt <= '0;
      else if (inc && (cnt != LAST))
         cnt <= cnt + 1'b1;
   end

   assign due = (cnt == LAST);

endmodule

// File: rtl/tx_link_scheduler.sv
// rtl/tx_link_scheduler.sv - 8B10B transmit sequencer: align burst, idle commas, framed payload
module tx_link_scheduler
   import tx_link_pkg::*;
#(
   parameter int ALIGN_LEN      = 16,
   parameter int COMMA_INTERVAL = 64,
   parameter int CNT_W          = 7
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       link_en,
   input  logic       s_valid,
   output logic       s_ready,
   input  logic [7:0] s_data,
   input  logic       s_last,
   output logic       enc_ena,
   output logic       enc_k,
   output logic [7:0] enc_din,
   output logic       aligned,
   output logic       busy
);

   localparam logic [CNT_W-1:0] ALIGN_LAST = CNT_W'(ALIGN_LEN - 1);

   state_t           state, nxt;
   sym_t             sym;
   logic [CNT_W-1:0] align_cnt;
   logic [CNT_W-1:0] comma_cnt;
   logic             comma_due, comma_clr, comma_inc;

   comma_interval_counter #(
      .CNT_W         (CNT_W),
      .COMMA_INTERVAL(COMMA_INTERVAL)
   ) u_comma_cnt (
      .clk(clk),
      .rst(rst),
      .clr(comma_clr),
      .inc(comma_inc),
      .cnt(comma_cnt),
      .due(comma_due)
   );

   assign s_ready = (state == DATA) && !comma_due;
   assign busy    = (state == DATA) || (state == EOF);

   always_comb begin
      nxt       = state;
      sym       = '{ena: 1'b0, k: enc_k, din: enc_din};
      comma_clr = 1'b0;
      comma_inc = 1'b0;
      case (state)
         DIS:   if (link_en) nxt = ALIGN;
         ABORT: nxt = DIS;
         ALIGN: begin
            if (!link_en) begin
               nxt = DIS;
            end else begin
               sym       = ksym(K28_5);
               comma_clr = 1'b1;
               if (align_cnt == ALIGN_LAST) nxt = IDLE;
            end
         end
         IDLE: begin
            if (!link_en) begin
               nxt = DIS;
            end else if (s_valid && (comma_cnt == '0)) begin
               // a nonzero count means the previous symbol was EOF; one comma must separate frames
               sym       = ksym(K27_7);
               comma_inc = 1'b1;
               nxt       = DATA;
            end else begin
               sym       = ksym(K28_5);
               comma_clr = 1'b1;
            end
         end
         DATA: begin
            if (!link_en) begin
               sym = ksym(K30_7);
               nxt = ABORT;
            end else if (comma_due) begin
               sym       = ksym(K28_5);
               comma_clr = 1'b1;
            end else if (s_valid) begin
               sym       = '{ena: 1'b1, k: 1'b0, din: s_data};
               comma_inc = 1'b1;
               if (s_last) nxt = EOF;
            end else begin
               sym       = ksym(K23_7);
               comma_inc = 1'b1;
            end
         end
         EOF: begin
            if (!link_en) begin
               sym = ksym(K30_7);
               nxt = ABORT;
            end else begin
               sym       = ksym(K29_7);
               comma_inc = 1'b1;
               nxt       = IDLE;
            end
         end
         default: nxt = DIS;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state     <= ALIGN;
         align_cnt <= '0;
         enc_ena   <= 1'b0;
         enc_k     <= 1'b0;
         enc_din   <= 8'h00;
         aligned   <= 1'b0;
      end else begin
         state     <= nxt;
         align_cnt <= (state == ALIGN) ? align_cnt + 1'b1 : '0;
         enc_ena   <= sym.ena;
         enc_k     <= sym.k;
         enc_din   <= sym.din;
         aligned   <= link_en && ((state == IDLE) || (state == DATA) || (state == EOF));
      end
   end

endmodule

// File: tb/tb_tx_link_scheduler.sv
// tb/tb_tx_link_scheduler.sv - self-checking bench for tx_link_scheduler
module tb_tx_link_scheduler;

   localparam int         CI    = 64;
   localparam logic [7:0] BC    = 8'hBC;
   localparam logic [7:0] SOF   = 8'hFB;
   localparam logic [7:0] EOFC  = 8'hFD;
   localparam logic [7:0] STALL = 8'hF7;
   localparam logic [7:0] ABRT  = 8'hFE;

   logic       clk = 1'b0;
   logic       rst;
   logic       link_en;
   logic       s_valid;
   logic       s_ready;
   logic [7:0] s_data;
   logic       s_last;
   logic       enc_ena;
   logic       enc_k;
   logic [7:0] enc_din;
   logic       aligned;
   logic       busy;

   int total = 0;
   int bad   = 0;

   tx_link_scheduler #(.ALIGN_LEN(16), .COMMA_INTERVAL(CI), .CNT_W(7)) dut (
      .clk(clk), .rst(rst), .link_en(link_en),
      .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data), .s_last(s_last),
      .enc_ena(enc_ena), .enc_k(enc_k), .enc_din(enc_din),
      .aligned(aligned), .busy(busy)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
      end
   endtask

   // Scoreboard on the encoder stream: payload order, stall/data rule, comma spacing
   byte unsigned q[$];
   int         gap = 0, frame_bc = 0, fd_cnt = 0;
   bit         in_frame = 0, p_ok = 0, p_valid = 0, p_rdy = 0;
   logic [7:0] p_data = 8'h00;

   always @(negedge clk) begin
      if (!rst) begin
         q.delete();
         in_frame = 0; gap = 0; p_ok = 0; p_rdy = 0;
      end else begin
         if (enc_ena) begin
            if (p_ok) begin
               if (p_valid) chk("xfer_sym", {enc_k, enc_din}, {1'b0, p_data});
               else         chk("stall_sym", {enc_k, enc_din}, {1'b1, STALL});
            end
            if (!enc_k) begin
               gap++;
               chk("data_in_frame", in_frame, 1);
               chk("byte_avail", q.size() != 0, 1);
               if (q.size() != 0) chk("payload", enc_din, q.pop_front());
            end else if (enc_din == BC) begin
               chk("comma_gap", gap <= (in_frame ? CI - 1 : CI), 1);
               if (in_frame) begin
                  chk("comma_ready", p_rdy, 0);
                  frame_bc++;
               end
               gap = 0;
            end else begin
               gap++;
               if (enc_din == SOF) begin in_frame = 1; frame_bc = 0; end
               if (enc_din == EOFC) begin in_frame = 0; fd_cnt++; end
               if (enc_din == ABRT) in_frame = 0;
            end
         end else begin
            gap = 0;
         end
         if (s_valid && s_ready && link_en) q.push_back(s_data);
         p_ok    = s_ready && link_en;
         p_rdy   = s_ready;
         p_valid = s_valid;
         p_data  = s_data;
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic align_seq(input int lead);
      for (int i = 0; i < lead; i++) begin
         tick();
         chk("align_lead_ena", enc_ena, 0);
      end
      for (int i = 0; i < 16; i++) begin
         tick();
         chk($sformatf("align%0d", i), {enc_ena, enc_k, enc_din, aligned}, {1'b1, 1'b1, BC, 1'b0});
      end
      tick();
      chk("align_done", {enc_ena, enc_k, enc_din, aligned}, {1'b1, 1'b1, BC, 1'b1});
   endtask

   task automatic drive_frame(input int len, input bit rnd);
      int   idx   = 0;
      int   guard = 0;
      logic r;
      logic [7:0] cur = 8'($urandom);
      while (idx < len && guard < 2000) begin
         s_valid = rnd ? ($urandom_range(0, 3) != 0) : 1'b1;
         s_data  = cur;
         s_last  = (idx == len - 1);
         r       = s_ready;
         tick();
         if (s_valid && r) begin
            idx++;
            cur = 8'($urandom);
         end
         guard++;
      end
      s_valid = 1'b0;
      s_last  = 1'b0;
      if (guard >= 2000) chk("frame_timeout", idx, len);
   endtask

   typedef struct {
      logic       valid;
      logic [7:0] data;
      logic       last;
      logic       rdy;
      logic       k;
      logic [7:0] din;
      logic       bsy;
   } vec_t;

   vec_t tv[22];

   initial begin
      int   acc;
      int   snap;
      logic r;
      tv[0]  = '{1'b1, 8'h01, 1'b0, 1'b0, 1'b1, SOF,   1'b1};
      tv[1]  = '{1'b1, 8'h01, 1'b0, 1'b1, 1'b0, 8'h01, 1'b1};
      tv[2]  = '{1'b1, 8'h02, 1'b0, 1'b1, 1'b0, 8'h02, 1'b1};
      tv[3]  = '{1'b1, 8'h03, 1'b1, 1'b1, 1'b0, 8'h03, 1'b1};
      tv[4]  = '{1'b0, 8'h00, 1'b0, 1'b0, 1'b1, EOFC,  1'b0};
      tv[5]  = '{1'b0, 8'h00, 1'b0, 1'b0, 1'b1, BC,    1'b0};
      tv[6]  = '{1'b1, 8'h11, 1'b0, 1'b0, 1'b1, SOF,   1'b1};
      tv[7]  = '{1'b1, 8'h11, 1'b0, 1'b1, 1'b0, 8'h11, 1'b1};
      tv[8]  = '{1'b0, 8'h00, 1'b0, 1'b1, 1'b1, STALL, 1'b1};
      tv[9]  = '{1'b0, 8'h00, 1'b0, 1'b1, 1'b1, STALL, 1'b1};
      tv[10] = '{1'b1, 8'h12, 1'b0, 1'b1, 1'b0, 8'h12, 1'b1};
      tv[11] = '{1'b1, 8'h13, 1'b1, 1'b1, 1'b0, 8'h13, 1'b1};
      tv[12] = '{1'b0, 8'h00, 1'b0, 1'b0, 1'b1, EOFC,  1'b0};
      tv[13] = '{1'b0, 8'h00, 1'b0, 1'b0, 1'b1, BC,    1'b0};
      tv[14] = '{1'b1, 8'h21, 1'b1, 1'b0, 1'b1, SOF,   1'b1};
      tv[15] = '{1'b1, 8'h21, 1'b1, 1'b1, 1'b0, 8'h21, 1'b1};
      tv[16] = '{1'b1, 8'h31, 1'b1, 1'b0, 1'b1, EOFC,  1'b0};
      tv[17] = '{1'b1, 8'h31, 1'b1, 1'b0, 1'b1, BC,    1'b0};
      tv[18] = '{1'b1, 8'h31, 1'b1, 1'b0, 1'b1, SOF,   1'b1};
      tv[19] = '{1'b1, 8'h31, 1'b1, 1'b1, 1'b0, 8'h31, 1'b1};
      tv[20] = '{1'b0, 8'h00, 1'b0, 1'b0, 1'b1, EOFC,  1'b0};
      tv[21] = '{1'b0, 8'h00, 1'b0, 1'b0, 1'b1, BC,    1'b0};

      rst = 1'b0; link_en = 1'b1; s_valid = 1'b0; s_data = 8'h00; s_last = 1'b0;
      repeat (3) tick();
      chk("reset_outputs", {enc_ena, enc_k, enc_din, aligned, busy, s_ready}, 0);
      rst = 1'b1;
      align_seq(0);

      // short frames, stalls and back-to-back frames
      for (int i = 0; i < 22; i++) begin
         s_valid = tv[i].valid;
         s_data  = tv[i].data;
         s_last  = tv[i].last;
         chk($sformatf("vec%0d_ready", i), s_ready, tv[i].rdy);
         tick();
         chk($sformatf("vec%0d_sym", i), {enc_ena, enc_k, enc_din}, {1'b1, tv[i].k, tv[i].din});
         chk($sformatf("vec%0d_busy", i), busy, tv[i].bsy);
      end

      // long frame forces exactly one mid-frame comma
      drive_frame(100, 1'b0);
      repeat (3) tick();
      chk("long_frame_commas", frame_bc, 1);

      // link drop mid-DATA
      acc = 0;
      for (int g = 0; g < 50 && acc < 5; g++) begin
         s_valid = 1'b1; s_data = 8'($urandom); s_last = 1'b0;
         r = s_ready;
         tick();
         if (r) acc++;
      end
      s_valid = 1'b0;
      link_en = 1'b0;
      tick();
      chk("abort_sym", {enc_ena, enc_k, enc_din, aligned, busy}, {1'b1, 1'b1, ABRT, 1'b0, 1'b0});
      tick();
      chk("abort_then_off", {enc_ena, enc_k, enc_din, s_ready}, {1'b0, 1'b1, ABRT, 1'b0});
      repeat (3) tick();
      chk("dis_quiet", {enc_ena, aligned, busy, s_ready}, 0);

      // re-enable, then reset mid-frame
      link_en = 1'b1;
      align_seq(1);
      s_valid = 1'b1; s_data = 8'h5A; s_last = 1'b0;
      repeat (4) tick();
      chk("pre_reset_busy", busy, 1);
      rst = 1'b0;
      #1;
      chk("async_reset", {enc_ena, enc_k, enc_din, aligned, busy, s_ready}, 0);
      s_valid = 1'b0;
      repeat (2) tick();
      rst = 1'b1;
      align_seq(0);

      // randomized frames against the stream scoreboard
      snap = fd_cnt;
      for (int f = 0; f < 6; f++) begin
         drive_frame($urandom_range(1, 150), 1'b1);
         repeat ($urandom_range(0, 2)) tick();
      end
      repeat (4) tick();
      chk("random_frames", fd_cnt - snap, 6);
      chk("queue_drained", q.size(), 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
